// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: function codes,
// legality check and controller state encoding.
package alu_pkg;

  localparam int FUNC_W = 6;

  localparam logic [5:0] FN_SLL  = 6'h04;
  localparam logic [5:0] FN_SRL  = 6'h06;
  localparam logic [5:0] FN_SRA  = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SEQ  = 6'h28;
  localparam logic [5:0] FN_SNE  = 6'h29;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SGT  = 6'h2B;
  localparam logic [5:0] FN_SLE  = 6'h2C;
  localparam logic [5:0] FN_SGE  = 6'h2D;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic is_legal_func(input logic [FUNC_W-1:0] f);
    case (f)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
      FN_OR, FN_XOR, FN_SEQ, FN_SNE, FN_SLT, FN_SGT, FN_SLE, FN_SGE:
        is_legal_func = 1'b1;
      default: is_legal_func = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic, logic, shifts and set-on-compare.
// cout is the adder carry; for subtraction it is the no-borrow flag.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6
) (
  input  logic [WIDTH-1:0]  d1,
  input  logic [WIDTH-1:0]  d2,
  input  logic [FUNC_W-1:0] func,
  output logic [WIDTH-1:0]  s,
  output logic              cout,
  output logic              zero_detect
);
  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SH_W-1:0]  shamt;
  logic             lt_s;
  logic             eq;

  assign add_w = {1'b0, d1} + {1'b0, d2};
  assign sub_w = {1'b0, d1} + {1'b0, ~d2} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt = d2[SH_W-1:0];
  assign lt_s  = $signed(d1) < $signed(d2);
  assign eq    = (d1 == d2);

  always_comb begin
    s    = '0;
    cout = 1'b0;
    case (func)
      FN_SLL:          s = d1 << shamt;
      FN_SRL:          s = d1 >> shamt;
      FN_SRA:          s = WIDTH'($signed(d1) >>> shamt);
      FN_ADD, FN_ADDU: {cout, s} = add_w;
      FN_SUB, FN_SUBU: {cout, s} = sub_w;
      FN_AND:          s = d1 & d2;
      FN_OR:           s = d1 | d2;
      FN_XOR:          s = d1 ^ d2;
      FN_SEQ:          s = {{(WIDTH-1){1'b0}}, eq};
      FN_SNE:          s = {{(WIDTH-1){1'b0}}, ~eq};
      FN_SLT:          s = {{(WIDTH-1){1'b0}}, lt_s};
      FN_SGT:          s = {{(WIDTH-1){1'b0}}, ~lt_s & ~eq};
      FN_SLE:          s = {{(WIDTH-1){1'b0}}, lt_s | eq};
      FN_SGE:          s = {{(WIDTH-1){1'b0}}, ~lt_s};
      default:         s = '0;
    endcase
  end

  assign zero_detect = (s == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between the execute stage (0) and the
// branch/compare unit (1), with a programmable settle time before capture.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FUNC_W      = 6,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req0_d1,
  input  logic [WIDTH-1:0]  req0_d2,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic [WIDTH-1:0]  req1_d1,
  input  logic [WIDTH-1:0]  req1_d2,
  input  logic [FUNC_W-1:0] req1_func,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_s,
  output logic              rsp_cout,
  output logic              rsp_zero,
  output logic              rsp_illegal,
  output logic              busy
);
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;
  logic              id_q, id_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  d1_q, d1_d, d2_q, d2_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d, zero_q, zero_d, ill_q, ill_d;
  logic              grant;
  logic [WIDTH-1:0]  alu_s;
  logic              alu_cout, alu_zero;

  // Only consulted while at least one requester is valid.
  assign grant = (req_valid == 2'b11) ? prio_q : req_valid[1];

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    func_d    = func_q;
    s_d       = s_q;
    cout_d    = cout_q;
    zero_d    = zero_q;
    ill_d     = ill_q;
    req_ready = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          id_d    = grant;
          d1_d    = grant ? req1_d1   : req0_d1;
          d2_d    = grant ? req1_d2   : req0_d2;
          func_d  = grant ? req1_func : req0_func;
          cnt_d   = CNT_INIT;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          // Illegal codes never sample the ALU, so nothing stale can leak out.
          if (is_legal_func(func_q)) begin
            s_d    = alu_s;
            cout_d = alu_cout;
            zero_d = alu_zero;
            ill_d  = 1'b0;
          end else begin
            s_d    = '0;
            cout_d = 1'b0;
            zero_d = 1'b1;
            ill_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready[id_q]) begin
          state_d = ST_IDLE;
          prio_d  = ~id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      func_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      func_q  <= func_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  alu #(.WIDTH(WIDTH), .FUNC_W(FUNC_W)) u_alu (
    .d1          (d1_q),
    .d2          (d2_q),
    .func        (func_q),
    .s           (alu_s),
    .cout        (alu_cout),
    .zero_detect (alu_zero)
  );

  assign rsp_valid   = (state_q == ST_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_s       = s_q;
  assign rsp_cout    = cout_q;
  assign rsp_zero    = zero_q;
  assign rsp_illegal = ill_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomised and directed bench for alu_share_ctrl with a queue-based
// scoreboard fed by a behavioural arbitration/ALU model.
module tb_alu_share_ctrl;
  localparam int EC = 3;

  typedef struct packed {
    logic        id;
    logic [31:0] s;
    logic        cout;
    logic        zero;
    logic        ill;
    int          acc;
  } exp_t;

  typedef struct packed {
    logic [5:0]  func;
    logic [31:0] d1;
    logic [31:0] d2;
  } op_t;

  logic        clk, reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req0_d1, req0_d2, req1_d1, req1_d2, rsp_s;
  logic [5:0]  req0_func, req1_func;
  logic        rsp_cout, rsp_zero, rsp_illegal, busy;

  alu_share_ctrl #(.WIDTH(32), .FUNC_W(6), .EXEC_CYCLES(EC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req0_d1(req0_d1), .req0_d2(req0_d2), .req0_func(req0_func),
    .req1_d1(req1_d1), .req1_d2(req1_d2), .req1_func(req1_func),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rsp = 0;
  int cyc = 0;
  exp_t sb[$];
  op_t opq0[$], opq1[$];
  logic gseq[$];
  logic mprio = 1'b0;
  logic [31:0] last_s [2];
  logic        last_cout [2];
  logic        last_ill [2];
  logic [1:0]  hs, rv;
  bit          rand_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the function-code definitions.
  function automatic exp_t ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic [32:0] t;
    r = '0;
    case (f)
      6'h04: r.s = a << b[4:0];
      6'h06: r.s = a >> b[4:0];
      6'h07: r.s = 32'($signed(a) >>> b[4:0]);
      6'h20, 6'h21: begin t = {1'b0, a} + {1'b0, b}; r.s = t[31:0]; r.cout = t[32]; end
      6'h22, 6'h23: begin r.s = a - b; r.cout = (a >= b); end
      6'h24: r.s = a & b;
      6'h25: r.s = a | b;
      6'h26: r.s = a ^ b;
      6'h28: r.s = {31'b0, a == b};
      6'h29: r.s = {31'b0, a != b};
      6'h2A: r.s = {31'b0, $signed(a) <  $signed(b)};
      6'h2B: r.s = {31'b0, $signed(a) >  $signed(b)};
      6'h2C: r.s = {31'b0, $signed(a) <= $signed(b)};
      6'h2D: r.s = {31'b0, $signed(a) >= $signed(b)};
      default: r.ill = 1'b1;
    endcase
    r.zero = (r.s == 32'd0);
    return r;
  endfunction

  // Monitor / scoreboard: the model holds at most one outstanding op.
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] exp_rdy, exp_v;
    cyc++;
    if (reset) begin
      sb.delete();
      mprio = 1'b0;
    end else if (sb.size() == 0) begin
      exp_rdy = (req_valid == 2'b11) ? (mprio ? 2'b10 : 2'b01) : req_valid;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy_idle", 64'(busy), 64'd0);
      chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
      if (exp_rdy != 2'b00) begin
        e = exp_rdy[1] ? ref_alu(req1_func, req1_d1, req1_d2) : ref_alu(req0_func, req0_d1, req0_d2);
        e.id  = exp_rdy[1];
        e.acc = cyc;
        sb.push_back(e);
        gseq.push_back(exp_rdy[1]);
      end
    end else begin
      e = sb[0];
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      chk("busy_active", 64'(busy), 64'd1);
      exp_v = (cyc - e.acc >= EC + 1) ? (e.id ? 2'b10 : 2'b01) : 2'b00;
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (exp_v != 2'b00) begin
        chk("rsp_s", 64'(rsp_s), 64'(e.s));
        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
        chk("rsp_illegal", 64'(rsp_illegal), 64'(e.ill));
        if (rsp_ready[e.id]) begin
          void'(sb.pop_front());
          mprio = ~e.id;
          last_s[e.id]    = rsp_s;
          last_cout[e.id] = rsp_cout;
          last_ill[e.id]  = rsp_illegal;
          n_rsp++;
          $display("rsp id=%0d s=0x%08h cout=%0d zero=%0d ill=%0d", e.id, rsp_s, rsp_cout, rsp_zero, rsp_illegal);
        end
      end
    end
  end

  task automatic apply();
    req_valid[0] = (opq0.size() != 0) && (!rand_mode || $urandom_range(0, 3) != 0);
    req_valid[1] = (opq1.size() != 0) && (!rand_mode || $urandom_range(0, 3) != 0);
    if (opq0.size() != 0) {req0_func, req0_d1, req0_d2} = opq0[0];
    if (opq1.size() != 0) {req1_func, req1_d1, req1_d2} = opq1[0];
  endtask

  task automatic cycle();
    @(negedge clk);
    hs = reset ? 2'b00 : (req_valid & req_ready);
    rv = rsp_valid;
    @(posedge clk);
    #1;
    if (hs[0]) void'(opq0.pop_front());
    if (hs[1]) void'(opq1.pop_front());
    if (rand_mode) rsp_ready = 2'($urandom_range(0, 3));
    apply();
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((opq0.size() != 0 || opq1.size() != 0 || sb.size() != 0) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_in_time", 64'(n < maxc), 64'd1);
  endtask

  function automatic op_t rand_op();
    logic [5:0] codes [16] = '{6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                               6'h25, 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D};
    op_t o;
    o.func = ($urandom_range(0, 9) == 0) ? 6'($urandom) : codes[$urandom_range(0, 15)];
    o.d1   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    o.d2   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    return o;
  endfunction

  initial begin
    int n, saved;
    reset = 1'b1; rsp_ready = 2'b00; req_valid = 2'b00;
    req0_d1 = '0; req0_d2 = '0; req0_func = '0;
    req1_d1 = '0; req1_d2 = '0; req1_func = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_s", 64'(rsp_s), 64'd0);
    chk("reset_rsp_flags", 64'({rsp_cout, rsp_zero, rsp_illegal}), 64'd0);
    reset = 1'b0;

    // 1: single ADD
    rsp_ready = 2'b11;
    opq0.push_back('{6'h20, 32'h7, 32'h9});
    apply(); drain(50);
    chk("t1_s", 64'(last_s[0]), 64'h10);

    // 2: both continuously valid; grants must alternate
    gseq.delete();
    repeat (4) begin
      opq0.push_back('{6'h22, 32'h5, 32'h5});
      opq1.push_back('{6'h25, 32'hF0, 32'h0F});
    end
    apply(); drain(200);
    for (int i = 1; i < gseq.size(); i++) chk("t2_alternate", 64'(gseq[i] != gseq[i-1]), 64'd1);
    chk("t2_req1_s", 64'(last_s[1]), 64'hFF);

    // 3: stalled response with carry; non-granted ready bit is high
    rsp_ready = 2'b01;
    opq1.push_back('{6'h21, 32'hFFFF_FFFF, 32'h1});
    apply();
    for (n = 0; n < 30 && !rv[1]; n++) cycle();
    chk("t3_rsp_seen", 64'(rv[1]), 64'd1);
    opq0.push_back('{6'h20, 32'h1, 32'h2});
    apply();
    repeat (5) begin
      cycle();
      chk("t3_no_accept", 64'(hs[0]), 64'd0);
    end
    rsp_ready = 2'b11;
    drain(50);
    chk("t3_s", 64'(last_s[1]), 64'h0);
    chk("t3_cout", 64'(last_cout[1]), 64'd1);

    // 4: illegal code then a legal shift
    opq0.push_back('{6'h3F, 32'h1234, 32'h5678});
    opq0.push_back('{6'h04, 32'h1, 32'h4});
    apply(); drain(50);
    chk("t4_s", 64'(last_s[0]), 64'h10);
    chk("t4_ill", 64'(last_ill[0]), 64'd0);

    // 5: reset during EXEC discards the op
    opq1.push_back('{6'h20, 32'h3, 32'h4});
    apply();
    for (n = 0; n < 30 && !hs[1]; n++) cycle();
    chk("t5_accept", 64'(hs[1]), 64'd1);
    saved = n_rsp;
    cycle();
    reset = 1'b1;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    cycle();
    reset = 1'b0;
    opq1.push_back('{6'h07, 32'h8000_0000, 32'h4});
    apply(); drain(50);
    chk("t5_sra", 64'(last_s[1]), 64'hF800_0000);
    chk("t5_rsp_count", 64'(n_rsp), 64'(saved + 1));
    gseq.delete();
    opq0.push_back('{6'h26, 32'hA, 32'h5});
    opq1.push_back('{6'h2A, 32'hFFFF_FFFF, 32'h1});
    apply(); drain(50);
    chk("t5_first_grant", 64'(gseq[0]), 64'd0);

    // random phase
    rand_mode = 1;
    repeat (40) begin
      opq0.push_back(rand_op());
      opq1.push_back(rand_op());
    end
    apply(); drain(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
